rv_imem_ctrl: RTL and testbench

Fetch-side controller for the instruction RAM (one 32-bit dual-port RAM: write port A, read port B, 1-cycle registered read). It holds the core in a boot-load phase while a program loader fills the RAM through port A, then sequences port B as a sequential fetch engine with a registered instruction output, decode back-pressure, branch redirect and a 1-entry skid buffer. In RUN it also accepts late loader writes and blocks fetch for those cycles so the same RAM address is never read and written in one cycle.

---
 rtl/rv_imem_ctrl.sv | 120 ++++++++++++
 tb/tb_rv_imem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_imem_ctrl.sv
// Instruction RAM fetch controller: boot-time loader gate, then a sequential
// fetch engine with a registered output, stall back-pressure, redirect and a 1-entry skid.
//
// state  | meaning
// S_LOAD | boot: loader fills RAM, no fetch issued
// S_RUN  | fetching; late loader writes pre-empt fetch
module rv_imem_ctrl #(
  parameter int          DEPTH    = 256,
  parameter logic [63:0] RESET_PC = 64'h0,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i,
  output logic          ld_ready_o,
  input  logic          ld_done_i,
  output logic          boot_o,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [63:0]   redirect_pc_i,
  output logic [63:0]   pc_o,
  output logic [31:0]   instr_o,
  output logic          instr_valid_o,
  output logic          ram_wena_o,
  output logic [AW-1:0] ram_addra_o,
  output logic [31:0]   ram_dina_o,
  output logic          ram_renb_o,
  output logic [AW-1:0] ram_addrb_o,
  input  logic [31:0]   ram_doutb_i
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state;
  logic [63:0] fetch_pc;
  logic        inflight;
  logic [63:0] inflight_pc;
  logic        skid_valid;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;

  logic        run;
  logic        redir;
  logic        issue;
  logic        out_free;
  logic [63:0] issue_pc;

  assign run      = (state == S_RUN);
  assign redir    = run & redirect_i;
  assign issue_pc = redirect_i ? redirect_pc_i : fetch_pc;
  assign out_free = ~instr_valid_o | ~stall_i;

  // A redirect flushes the skid and output, so it may issue regardless of them;
  // otherwise holding issue while stalled with a read in flight keeps the skid from overflowing.
  assign issue = run & ~ld_valid_i &
                 (redir | (~skid_valid & ~(stall_i & instr_valid_o & inflight)));

  assign ld_ready_o  = 1'b1;
  assign boot_o      = (state == S_LOAD);
  assign ram_wena_o  = ld_valid_i;
  assign ram_addra_o = ld_addr_i;
  assign ram_dina_o  = ld_data_i;
  assign ram_renb_o  = issue;
  assign ram_addrb_o = issue_pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_pc   <= 64'h0;
      skid_valid    <= 1'b0;
      skid_pc       <= 64'h0;
      skid_instr    <= 32'h0;
      instr_valid_o <= 1'b0;
      pc_o          <= 64'h0;
      instr_o       <= 32'h0;
    end else begin
      if (state == S_LOAD && ld_done_i) begin
        state <= S_RUN;
      end

      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        fetch_pc    <= issue_pc + 64'd4;
      end else if (redir) begin
        fetch_pc <= redirect_pc_i;
      end

      if (redir) begin
        instr_valid_o <= 1'b0;
        skid_valid    <= 1'b0;
      end else if (out_free) begin
        if (skid_valid) begin
          instr_valid_o <= 1'b1;
          pc_o          <= skid_pc;
          instr_o       <= skid_instr;
          skid_valid    <= inflight;
          skid_pc       <= inflight_pc;
          skid_instr    <= ram_doutb_i;
        end else if (inflight) begin
          instr_valid_o <= 1'b1;
          pc_o          <= inflight_pc;
          instr_o       <= ram_doutb_i;
        end else begin
          instr_valid_o <= 1'b0;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_pc    <= inflight_pc;
        skid_instr <= ram_doutb_i;
      end
    end
  end

endmodule

// File: tb/tb_rv_imem_ctrl.sv
// Bench for rv_imem_ctrl: directed boot/stall/redirect/loader/reset steps, then
// randomized traffic checked against an instruction-stream model.
module tb_rv_imem_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          boot;
  logic          stall;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic [63:0]   pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          ram_wena;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic          ram_renb;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_doutb;

  always #5 clk = ~clk;

  rv_imem_ctrl #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .ld_done_i(ld_done), .boot_o(boot),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .pc_o(pc), .instr_o(instr), .instr_valid_o(instr_valid),
    .ram_wena_o(ram_wena), .ram_addra_o(ram_addra), .ram_dina_o(ram_dina),
    .ram_renb_o(ram_renb), .ram_addrb_o(ram_addrb), .ram_doutb_i(ram_doutb)
  );

  // dual-port RAM, registered read
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wena) ram[ram_addra] <= ram_dina;
    if (ram_renb) ram_doutb <= ram[ram_addrb];
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [DEPTH];

  logic [63:0] exp_pc;
  logic        prev_redir;
  logic        prev_hold;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;
  int          idle_cnt;
  logic        found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_done = 0;
    stall = 0; redirect = 0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_boot", boot, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_renb", ram_renb, 0);
    chk("rst_wena", ram_wena, 0);
    chk("ld_ready", ld_ready, 1);

    // boot load of words 0..3
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_valid = 1; ld_addr = AW'(i); ld_data = 32'h11 * (i + 1);
      @(negedge clk);
      chk("load_wena", ram_wena, 1);
      chk("load_addra", ram_addra, i);
      chk("load_renb", ram_renb, 0);
    end
    tick(); ld_valid = 0; ld_done = 1;
    @(negedge clk);
    chk("done_boot", boot, 1);
    chk("done_renb", ram_renb, 0);
    tick(); ld_done = 0;
    @(negedge clk);
    chk("run_boot", boot, 0);
    chk("first_issue", ram_renb, 1);
    chk("first_addr", ram_addrb, 0);
    tick(); @(negedge clk);
    chk("lat_valid0", instr_valid, 0);
    tick(); @(negedge clk);
    chk("boot_v0", instr_valid, 1);
    chk("boot_pc0", pc, 0);
    chk("boot_i0", instr, 32'h11);

    // stall 3 cycles with PC 4 on the output
    for (int i = 0; i < 3; i++) begin
      tick(); stall = 1;
      @(negedge clk);
      chk("stall_pc", pc, 4);
      chk("stall_instr", instr, 32'h22);
      chk("stall_valid", instr_valid, 1);
      chk("stall_no_issue", ram_renb, 0);
    end
    tick(); stall = 0;
    @(negedge clk);
    chk("release_pc", pc, 4);
    chk("release_no_issue", ram_renb, 0);
    tick(); @(negedge clk);
    chk("resume_pc8", pc, 8);
    chk("resume_i8", instr, 32'h33);
    found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      tick(); @(negedge clk);
      if (instr_valid) found = 1;
    end
    chk("resume_found12", found, 1);
    chk("resume_pc12", pc, 12);
    chk("resume_i12", instr, 32'h44);

    // redirect back to 8, then redirect to 0x400 while 8 is on the output
    tick(); redirect = 1; redirect_pc = 64'h8;
    @(negedge clk);
    chk("redir8_issue", ram_renb, 1);
    chk("redir8_addr", ram_addrb, 2);
    tick(); redirect = 0;
    @(negedge clk);
    chk("redir8_flush", instr_valid, 0);
    tick(); redirect = 1; redirect_pc = 64'h400;
    @(negedge clk);
    chk("redir_at8_pc", pc, 8);
    chk("redir_at8_i", instr, 32'h33);
    chk("redir400_addr", ram_addrb, 0);
    chk("redir400_issue", ram_renb, 1);
    tick(); redirect = 0;
    @(negedge clk);
    chk("redir400_flush", instr_valid, 0);
    tick(); @(negedge clk);
    chk("redir400_valid", instr_valid, 1);
    chk("redir400_pc", pc, 64'h400);
    chk("redir400_i", instr, 32'h11);
    tick(); @(negedge clk);
    chk("redir404_pc", pc, 64'h404);
    chk("redir404_i", instr, 32'h22);

    // late loader write to word 5 while running
    tick(); ld_valid = 1; ld_addr = 8'd5; ld_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("late_wena", ram_wena, 1);
    chk("late_no_issue", ram_renb, 0);
    chk("late_dina", ram_dina, 32'hDEADBEEF);
    tick(); ld_valid = 0;
    @(negedge clk);
    chk("late_resume", ram_renb, 1);
    tick(); redirect = 1; redirect_pc = 64'h14;
    @(negedge clk);
    chk("w5_addr", ram_addrb, 5);
    tick(); redirect = 0;
    @(negedge clk);
    tick(); @(negedge clk);
    chk("w5_pc", pc, 64'h14);
    chk("w5_instr", instr, 32'hDEADBEEF);

    // reset while stalled with the skid full
    tick(); stall = 1;
    @(negedge clk);
    chk("pre_rst_valid", instr_valid, 1);
    tick(); rst = 1;
    @(negedge clk);
    chk("pre_rst_no_issue", ram_renb, 0);
    tick(); rst = 0; stall = 0;
    @(negedge clk);
    chk("mid_rst_boot", boot, 1);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_renb", ram_renb, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("load_hold_renb", ram_renb, 0);
    end

    // full reload, ld_done on the last write
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      ld_valid = 1; ld_addr = AW'(i); ld_data = $urandom;
      ref_mem[i] = ld_data;
      ld_done = (i == DEPTH - 1);
    end
    @(negedge clk);
    chk("reload_boot", boot, 1);
    tick(); ld_valid = 0; ld_done = 0;
    @(negedge clk);
    chk("reload_run", boot, 0);
    chk("reload_addr", ram_addrb, 0);
    tick(); @(negedge clk);
    chk("reload_valid0", instr_valid, 0);
    tick(); @(negedge clk);
    chk("reload_pc", pc, 0);
    chk("reload_instr", instr, {32'h0, ref_mem[0]});

    // randomized traffic against the stream model
    exp_pc = 64'h4; prev_redir = 0; prev_hold = 0; idle_cnt = 0;
    prev_pc = '0; prev_instr = '0;
    for (int n = 0; n < 2000; n++) begin
      tick();
      stall       = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = {$urandom, $urandom} & ~64'h3;
      ld_valid    = ($urandom_range(7) == 0);
      ld_addr     = AW'($urandom);
      ld_data     = ref_mem[ld_addr];
      @(negedge clk);
      chk("rnd_wena", ram_wena, ld_valid);
      if (ld_valid) chk("rnd_no_rw_conflict", ram_renb, 0);
      if (prev_redir) begin
        chk("rnd_redir_flush", instr_valid, 0);
      end else if (prev_hold) begin
        chk("rnd_hold_valid", instr_valid, 1);
        chk("rnd_hold_pc", pc, prev_pc);
        chk("rnd_hold_instr", instr, prev_instr);
      end
      if (instr_valid) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instr, ref_mem[pc[9:2]]);
        idle_cnt = 0;
      end else begin
        idle_cnt++;
        chk("rnd_progress_budget", (idle_cnt > 30), 0);
      end
      prev_redir = redirect;
      prev_hold  = instr_valid & stall & ~redirect;
      prev_pc    = pc;
      prev_instr = instr;
      if (redirect) exp_pc = redirect_pc;
      else if (instr_valid && !stall) exp_pc = exp_pc + 64'd4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
